// File: rtl/timing_control_unit_pkg.sv
// rtl/timing_control_unit_pkg.sv - shared cpu6502 timing defines: interrupt kind codes, BRK opcode, T-counter width
package timing_control_unit_pkg;

    localparam int TCU_WIDTH_DEF = 3;
    localparam int IR_WIDTH_DEF  = 8;
    localparam logic [7:0] BRK_OPCODE_DEF = 8'h00;

    typedef enum logic [1:0] {
        INT_KIND_NONE  = 2'd0,
        INT_KIND_IRQ   = 2'd1,
        INT_KIND_NMI   = 2'd2,
        INT_KIND_RESET = 2'd3
    } int_kind_e;

endpackage

// File: rtl/timing_control_unit_if.sv
// rtl/timing_control_unit_if.sv - timing control bus; TCU_SINGLE_STEP_EN adds i_step
interface timing_control_unit_if #(
    parameter int TCU_WIDTH = 3,
    parameter int IR_WIDTH  = 8,
    parameter int IRQ_LINES = 1
);
    logic                 i_rdy;
    logic [IR_WIDTH-1:0]  i_data;
    logic                 i_done;
    logic                 i_irq_mask;
    logic [IRQ_LINES-1:0] i_irq_n;
    logic                 i_nmi_n;
`ifdef TCU_SINGLE_STEP_EN
    logic                 i_step;
`endif
    logic [TCU_WIDTH-1:0] o_tcu;
    logic [IR_WIDTH-1:0]  o_ir;
    logic                 o_sync;
    logic                 o_interrupt;
    logic [1:0]           o_int_kind;
    logic                 o_tcu_overflow;

`ifdef TCU_SINGLE_STEP_EN
    modport master (
        output i_rdy, i_data, i_done, i_irq_mask, i_irq_n, i_nmi_n, i_step,
        input  o_tcu, o_ir, o_sync, o_interrupt, o_int_kind, o_tcu_overflow
    );
    modport slave (
        input  i_rdy, i_data, i_done, i_irq_mask, i_irq_n, i_nmi_n, i_step,
        output o_tcu, o_ir, o_sync, o_interrupt, o_int_kind, o_tcu_overflow
    );
`else
    modport master (
        output i_rdy, i_data, i_done, i_irq_mask, i_irq_n, i_nmi_n,
        input  o_tcu, o_ir, o_sync, o_interrupt, o_int_kind, o_tcu_overflow
    );
    modport slave (
        input  i_rdy, i_data, i_done, i_irq_mask, i_irq_n, i_nmi_n,
        output o_tcu, o_ir, o_sync, o_interrupt, o_int_kind, o_tcu_overflow
    );
`endif
endinterface

// File: rtl/timing_control_unit_interrupt_latch.sv
// rtl/timing_control_unit_interrupt_latch.sv - NMI falling-edge latch and masked level IRQ request
module timing_control_unit_interrupt_latch #(
    parameter int IRQ_LINES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_nmi_n,
    input  logic [IRQ_LINES-1:0] i_irq_n,
    input  logic                 i_irq_mask,
    input  logic                 take_nmi,
    output logic                 nmi_req,
    output logic                 irq_req
);
    logic nmi_prev;
    logic nmi_pending;
    logic nmi_edge;

    assign nmi_edge = nmi_prev & ~i_nmi_n;

    // A fresh edge in the capture cycle outranks the clear, so it is not lost.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            nmi_prev    <= 1'b1;
            nmi_pending <= 1'b0;
        end else begin
            nmi_prev <= i_nmi_n;
            if (nmi_edge)
                nmi_pending <= 1'b1;
            else if (take_nmi)
                nmi_pending <= 1'b0;
        end
    end

    assign nmi_req = nmi_pending;
    assign irq_req = (~&i_irq_n) & ~i_irq_mask;

endmodule

// File: rtl/timing_control_unit.sv
// rtl/timing_control_unit.sv - T-state counter, IR and interrupt injection; TCU_SINGLE_STEP_EN enables single-step gating
module timing_control_unit
    import timing_control_unit_pkg::*;
#(
    parameter int                  TCU_WIDTH  = TCU_WIDTH_DEF,
    parameter int                  MAX_T      = 7,
    parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
    parameter int                  IRQ_LINES  = 1,
    parameter logic [IR_WIDTH-1:0] BRK_OPCODE = IR_WIDTH'(BRK_OPCODE_DEF)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    timing_control_unit_if.slave  bus
);
    localparam logic [TCU_WIDTH-1:0] T_MAX = TCU_WIDTH'(MAX_T);
    localparam logic [TCU_WIDTH-1:0] T_ONE = TCU_WIDTH'(1);

    logic [TCU_WIDTH-1:0] tcu;
    logic [IR_WIDTH-1:0]  ir;
    int_kind_e            int_kind;
    logic                 interrupt;
    logic                 overflow;
    logic                 nmi_req;
    logic                 irq_req;
    logic                 capture;
    logic                 take_nmi;

`ifdef TCU_SINGLE_STEP_EN
    logic step_prev;
    logic step_armed;

    assign capture = bus.i_rdy && (tcu == '0) && step_armed;

    // Reset arms one capture so the reset sequence hands off to the first instruction.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            step_prev  <= 1'b0;
            step_armed <= 1'b1;
        end else begin
            step_prev <= bus.i_step;
            if (bus.i_step && !step_prev)
                step_armed <= 1'b1;
            else if (capture)
                step_armed <= 1'b0;
        end
    end
`else
    assign capture = bus.i_rdy && (tcu == '0);
`endif

    assign take_nmi = capture && nmi_req;

    timing_control_unit_interrupt_latch #(
        .IRQ_LINES (IRQ_LINES)
    ) u_interrupt_latch (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_nmi_n    (bus.i_nmi_n),
        .i_irq_n    (bus.i_irq_n),
        .i_irq_mask (bus.i_irq_mask),
        .take_nmi   (take_nmi),
        .nmi_req    (nmi_req),
        .irq_req    (irq_req)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tcu       <= T_ONE;
            ir        <= BRK_OPCODE;
            int_kind  <= INT_KIND_RESET;
            interrupt <= 1'b1;
            overflow  <= 1'b0;
        end else if (bus.i_rdy) begin
            if (tcu == '0) begin
                if (capture) begin
                    tcu <= T_ONE;
                    if (nmi_req) begin
                        ir        <= BRK_OPCODE;
                        int_kind  <= INT_KIND_NMI;
                        interrupt <= 1'b1;
                    end else if (irq_req) begin
                        ir        <= BRK_OPCODE;
                        int_kind  <= INT_KIND_IRQ;
                        interrupt <= 1'b1;
                    end else begin
                        ir        <= bus.i_data;
                        int_kind  <= INT_KIND_NONE;
                        interrupt <= 1'b0;
                    end
                end
            end else if (bus.i_done) begin
                tcu <= '0;
            end else if (tcu == T_MAX) begin
                overflow <= 1'b1;
            end else begin
                tcu <= tcu + T_ONE;
            end
        end
    end

    assign bus.o_tcu          = tcu;
    assign bus.o_ir           = ir;
    assign bus.o_int_kind     = int_kind;
    assign bus.o_interrupt    = interrupt;
    assign bus.o_tcu_overflow = overflow;
    assign bus.o_sync         = (tcu == '0);

endmodule

// File: tb/tb_timing_control_unit.sv
// tb/tb_timing_control_unit.sv - directed self-checking bench for timing_control_unit
module tb_timing_control_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;

    timing_control_unit_if #(.TCU_WIDTH(3), .IR_WIDTH(8), .IRQ_LINES(1)) tcu_bus ();

    timing_control_unit dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (tcu_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset_n            = 1'b0;
        tcu_bus.i_rdy      = 1'b1;
        tcu_bus.i_data     = 8'h00;
        tcu_bus.i_done     = 1'b0;
        tcu_bus.i_irq_mask = 1'b1;
        tcu_bus.i_irq_n    = 1'b1;
        tcu_bus.i_nmi_n    = 1'b1;
`ifdef TCU_SINGLE_STEP_EN
        tcu_bus.i_step     = 1'b0;
`endif
        tick();
        tick();
        check("rst_tcu", 32'(tcu_bus.o_tcu), 32'd1);
        check("rst_ir", 32'(tcu_bus.o_ir), 32'h00);
        check("rst_kind", 32'(tcu_bus.o_int_kind), 32'd3);
        check("rst_interrupt", 32'(tcu_bus.o_interrupt), 32'd1);
        check("rst_overflow", 32'(tcu_bus.o_tcu_overflow), 32'd0);
        check("rst_sync", 32'(tcu_bus.o_sync), 32'd0);

        // reset sequence T1..T6 then done
        reset_n = 1'b1;
        tick();
        check("rst_seq_t2", 32'(tcu_bus.o_tcu), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        check("rst_seq_t6", 32'(tcu_bus.o_tcu), 32'd6);
        tcu_bus.i_done = 1'b1;
        tick();
        check("rst_seq_t0", 32'(tcu_bus.o_tcu), 32'd0);
        check("rst_seq_sync", 32'(tcu_bus.o_sync), 32'd1);
        tcu_bus.i_done = 1'b0;
        tcu_bus.i_data = 8'hA9;
        tick();
        check("fetch_a9_ir", 32'(tcu_bus.o_ir), 32'hA9);
        check("fetch_a9_interrupt", 32'(tcu_bus.o_interrupt), 32'd0);
        check("fetch_a9_kind", 32'(tcu_bus.o_int_kind), 32'd0);
        check("fetch_a9_tcu", 32'(tcu_bus.o_tcu), 32'd1);

        // normal flow: EA, done at T1 -> T0,T1,T0
        tcu_bus.i_done = 1'b1;
        tick();
        check("nf_t0a", 32'(tcu_bus.o_tcu), 32'd0);
        tcu_bus.i_done = 1'b0;
        tcu_bus.i_data = 8'hEA;
        tick();
        check("nf_t1", 32'(tcu_bus.o_tcu), 32'd1);
        check("nf_ir", 32'(tcu_bus.o_ir), 32'hEA);
        check("nf_sync_t1", 32'(tcu_bus.o_sync), 32'd0);
        tcu_bus.i_done = 1'b1;
        tick();
        check("nf_t0b", 32'(tcu_bus.o_tcu), 32'd0);
        check("nf_sync_t0", 32'(tcu_bus.o_sync), 32'd1);

        // i_done ignored in T0
        tcu_bus.i_data = 8'hEA;
        tick();
        check("t0_done_ignored", 32'(tcu_bus.o_tcu), 32'd1);
        tcu_bus.i_done = 1'b0;
        tick();
        check("stall_pre_t2", 32'(tcu_bus.o_tcu), 32'd2);

        // RDY stall with NMI edge inside it
        tcu_bus.i_rdy   = 1'b0;
        tcu_bus.i_nmi_n = 1'b0;
        tcu_bus.i_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_tcu", 32'(tcu_bus.o_tcu), 32'd2);
            check("stall_ir", 32'(tcu_bus.o_ir), 32'hEA);
        end
        tcu_bus.i_rdy  = 1'b1;
        tcu_bus.i_done = 1'b1;
        tick();
        check("stall_t0", 32'(tcu_bus.o_tcu), 32'd0);
        tcu_bus.i_done = 1'b0;
        tick();
        check("stall_nmi_kind", 32'(tcu_bus.o_int_kind), 32'd2);
        check("stall_nmi_ir", 32'(tcu_bus.o_ir), 32'h00);
        check("stall_nmi_interrupt", 32'(tcu_bus.o_interrupt), 32'd1);
        tcu_bus.i_nmi_n = 1'b1;
        tick();

        // priority: NMI edge pending and IRQ asserted at the same T0
        tcu_bus.i_nmi_n    = 1'b0;
        tcu_bus.i_irq_n    = 1'b0;
        tcu_bus.i_irq_mask = 1'b0;
        tcu_bus.i_done     = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        tick();
        check("prio_nmi_first", 32'(tcu_bus.o_int_kind), 32'd2);
        tcu_bus.i_done = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        tick();
        check("prio_irq_next", 32'(tcu_bus.o_int_kind), 32'd1);
        check("prio_irq_ir", 32'(tcu_bus.o_ir), 32'h00);
        tcu_bus.i_irq_mask = 1'b1;
        tcu_bus.i_data     = 8'h4C;
        tcu_bus.i_done     = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        tick();
        check("masked_kind", 32'(tcu_bus.o_int_kind), 32'd0);
        check("masked_ir", 32'(tcu_bus.o_ir), 32'h4C);
        check("masked_interrupt", 32'(tcu_bus.o_interrupt), 32'd0);
        tcu_bus.i_irq_n = 1'b1;
        tcu_bus.i_nmi_n = 1'b1;

        // overflow: never assert done
        for (int i = 0; i < 6; i++) tick();
        check("ovf_t7", 32'(tcu_bus.o_tcu), 32'd7);
        check("ovf_not_yet", 32'(tcu_bus.o_tcu_overflow), 32'd0);
        tick();
        check("ovf_hold", 32'(tcu_bus.o_tcu), 32'd7);
        check("ovf_set", 32'(tcu_bus.o_tcu_overflow), 32'd1);
        tcu_bus.i_done = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        check("ovf_sticky_t0", 32'(tcu_bus.o_tcu), 32'd0);
        check("ovf_sticky", 32'(tcu_bus.o_tcu_overflow), 32'd1);

        // reset mid-stall wins
        tcu_bus.i_rdy = 1'b0;
        reset_n       = 1'b0;
        tick();
        check("rst2_tcu", 32'(tcu_bus.o_tcu), 32'd1);
        check("rst2_kind", 32'(tcu_bus.o_int_kind), 32'd3);
        check("rst2_overflow", 32'(tcu_bus.o_tcu_overflow), 32'd0);
        reset_n       = 1'b1;
        tcu_bus.i_rdy = 1'b1;

`ifdef TCU_SINGLE_STEP_EN
        tcu_bus.i_done = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        tcu_bus.i_data = 8'hA9;
        tick();
        check("ss_first_ir", 32'(tcu_bus.o_ir), 32'hA9);
        tcu_bus.i_done = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        tcu_bus.i_data = 8'hEA;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ss_hold_tcu", 32'(tcu_bus.o_tcu), 32'd0);
            check("ss_hold_sync", 32'(tcu_bus.o_sync), 32'd1);
        end
        tcu_bus.i_step = 1'b1;
        tick();
        check("ss_arm_tcu", 32'(tcu_bus.o_tcu), 32'd0);
        tcu_bus.i_step = 1'b0;
        tick();
        check("ss_cap_tcu", 32'(tcu_bus.o_tcu), 32'd1);
        check("ss_cap_ir", 32'(tcu_bus.o_ir), 32'hEA);
        tcu_bus.i_done = 1'b1;
        tick();
        tcu_bus.i_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ss_rehold", 32'(tcu_bus.o_tcu), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
